// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, LSB first, one full-subtractor cell.
// Latency: accept edge + WIDTH processing edges; done pulses the cycle after edge WIDTH.
// Backpressure: none; start is only sampled in IDLE, ignored while busy (not queued).
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start, a, b, bin  request and operands, captured on the accepting edge
//   busy, done        busy in RUN/DONE; done is a one-cycle result-valid pulse
//   diff, bout, ovf   result, unsigned borrow-out, signed overflow (held until next result)
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic             w_x;
    logic             w_y;
    logic             w_z;
    logic             w_d;
    logic             w_bnext;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    // Full-subtractor cell on the current LSBs and the registered borrow.
    assign w_x     = r_a_sh[0];
    assign w_y     = r_b_sh[0];
    assign w_z     = r_borrow;
    assign w_d     = w_x ^ w_y ^ w_z;
    assign w_bnext = (~w_x & w_y) | (~w_x & w_z) | (w_y & w_z);
    assign w_last  = (r_cnt == CW'(WIDTH - 1));

    // Result fills from the MSB end, so after WIDTH shifts bit 0 is the first
    // computed bit. Written this way so WIDTH=1 needs no zero-width slice.
    always_comb begin
        w_res_next            = r_res >> 1;
        w_res_next[WIDTH-1]   = w_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_borrow <= bin;
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
                        r_cnt    <= '0;
                        r_res    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_res    <= w_res_next;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_borrow <= w_bnext;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        // Visible outputs update only here, all at once.
                        r_diff  <= w_res_next;
                        r_bout  <= w_bnext;
                        // w_d is the final diff MSB.
                        r_ovf   <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule
